// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory line responder.
package dmem_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Line number of a byte address; callers truncate to their index width.
  function automatic logic [31:0] line_of(input logic [31:0] addr);
    return addr >> OFFSET_W;
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Single-port line storage: synchronous write, registered read. No reset.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned WIDTH      = LINE_W
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] r_mem [0:(1 << DEPTH_LOG2)-1];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[addr_i] <= wdata_i;
    end
    if (re_i) begin
      r_rdata <= r_mem[addr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_line_responder.sv
// Memory-side end of the dcache line interface: one line read/write per
// request, completed with a one-cycle ack after a fixed latency.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY    = 10,
  parameter int unsigned LINE_W     = dmem_pkg::LINE_W,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam int unsigned     CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

  state_t                  r_state, w_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic                    r_write;
  logic [LINE_W-1:0]       r_wdata;
  logic                    r_ack, r_busy, r_rd_valid;
  logic                    w_access, w_we, w_re;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic [LINE_W-1:0]       w_rdata;

  assign w_idx = DEPTH_LOG2'(line_of(addr_i));

  // The access always happens on the WAIT->ACK edge, so ack sits in the cycle
  // starting LATENCY edges after capture, even when LATENCY is 1.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_access   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable_i) begin
          w_next     = ST_WAIT;
          w_cnt_next = CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CNT_LAST) begin
          w_next   = ST_ACK;
          w_access = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_we = w_access &  r_write & rst_i;
  assign w_re = w_access & ~r_write & rst_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_ack   <= (w_next == ST_ACK);
      r_busy  <= (w_next != ST_IDLE);
      if (w_re) begin
        r_rd_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == ST_IDLE && enable_i) begin
      r_idx   <= w_idx;
      r_write <= write_i;
      r_wdata <= data_i;
    end
  end

  dmem_line_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (LINE_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_we),
    .re_i    (w_re),
    .addr_i  (r_idx),
    .wdata_i (r_wdata),
    .rdata_o (w_rdata)
  );

  // Read register holds garbage until the first read after reset.
  assign data_o = r_rd_valid ? w_rdata : '0;
  assign ack_o  = r_ack;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Randomised bench for dmem_line_responder: LATENCY=10 and LATENCY=1 builds
// checked against a line-array model.
module tb_dmem_line_responder;

  localparam int unsigned LW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          en_a, wr_a, ack_a, busy_a;
  logic [31:0]   addr_a;
  logic [LW-1:0] din_a, dout_a;
  logic          en_b, wr_b, ack_b, busy_b;
  logic [31:0]   addr_b;
  logic [LW-1:0] din_b, dout_b;

  dmem_line_responder #(.LATENCY(10), .LINE_W(256), .DEPTH_LOG2(9)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en_a), .write_i(wr_a), .addr_i(addr_a),
    .data_i(din_a), .ack_o(ack_a), .data_o(dout_a), .busy_o(busy_a)
  );

  dmem_line_responder #(.LATENCY(1), .LINE_W(256), .DEPTH_LOG2(9)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en_b), .write_i(wr_b), .addr_i(addr_b),
    .data_i(din_b), .ack_o(ack_b), .data_o(dout_b), .busy_o(busy_b)
  );

  int checks   = 0;
  int failures = 0;

  logic [LW-1:0] mem_m  [2][512];
  logic [LW-1:0] last_m [2];
  int            lat_m  [2] = '{10, 1};

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int unsigned line_idx(input logic [31:0] a);
    return (a / 32) % 512;
  endfunction

  function automatic logic get_ack(input int s);
    return (s == 0) ? ack_a : ack_b;
  endfunction

  function automatic logic get_busy(input int s);
    return (s == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic [LW-1:0] get_dout(input int s);
    return (s == 0) ? dout_a : dout_b;
  endfunction

  task automatic drive(input int s, input logic e, input logic w,
                       input logic [31:0] a, input logic [LW-1:0] d);
    if (s == 0) begin
      en_a = e; wr_a = w; addr_a = a; din_a = d;
    end else begin
      en_b = e; wr_b = w; addr_b = a; din_b = d;
    end
  endtask

  // Issues one request, returns edges from capture to the ack cycle (-1 on timeout),
  // and applies the request to the model. Leaves time at the ack-cycle negedge.
  task automatic txn(input int s, input logic w, input logic [31:0] a,
                     input logic [LW-1:0] d, input bit churn, input bit hold,
                     output int lat);
    @(negedge clk);
    drive(s, 1'b1, w, a, d);
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (get_ack(s)) begin
        lat = k;
        break;
      end
      if (churn) drive(s, 1'b1, 1'($urandom_range(0, 1)), $urandom(), rand_line());
    end
    if (churn) drive(s, hold, 1'($urandom_range(0, 1)), $urandom(), rand_line());
    else if (!hold) drive(s, 1'b0, w, a, d);
    if (w) mem_m[s][line_idx(a)] = d;
    else   last_m[s] = mem_m[s][line_idx(a)];
  endtask

  task automatic preload(input int s);
    int lat;
    for (int i = 0; i < 512; i++) begin
      logic [LW-1:0] d;
      d = (i == 3) ? {32{8'hA5}} : rand_line();
      txn(s, 1'b1, 32'(i * 32), d, 1'b0, 1'b0, lat);
      checks++;
      if (lat != lat_m[s]) begin
        failures++;
        $display("FAIL preload_latency dut=%0d line=%0d got=%0d exp=%0d", s, i, lat, lat_m[s]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (get_ack(s) !== 1'b0) begin
        failures++; $display("FAIL reset_ack dut=%0d got=%b exp=0", s, get_ack(s));
      end
      checks++;
      if (get_busy(s) !== 1'b0) begin
        failures++; $display("FAIL reset_busy dut=%0d got=%b exp=0", s, get_busy(s));
      end
      checks++;
      if (get_dout(s) !== '0) begin
        failures++; $display("FAIL reset_data dut=%0d got=%h exp=0", s, get_dout(s));
      end
      last_m[s] = '0;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_latency();
    int lat;
    txn(0, 1'b0, 32'h60, '0, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 10) begin failures++; $display("FAIL rd_latency got=%0d exp=10", lat); end
    checks++;
    if (dout_a !== {32{8'hA5}}) begin failures++; $display("FAIL rd_data got=%h exp=%h", dout_a, {32{8'hA5}}); end
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL rd_busy_at_ack got=%b exp=1", busy_a); end
    @(negedge clk);
    checks++;
    if (ack_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL rd_after_ack ack=%b busy=%b exp=0/0", ack_a, busy_a);
    end
  endtask

  task automatic test_write_read();
    int lat;
    txn(0, 1'b1, 32'h80, 256'h1234, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 10 || dout_a !== last_m[0]) begin
      failures++; $display("FAIL wr_ack lat=%0d data=%h exp lat=10 data=%h", lat, dout_a, last_m[0]);
    end
    txn(0, 1'b0, 32'h9C, '0, 1'b0, 1'b0, lat);
    checks++;
    if (dout_a !== 256'h1234) begin failures++; $display("FAIL wr_then_rd got=%h exp=1234", dout_a); end
  endtask

  task automatic test_back_to_back();
    int lat, gap, extra;
    logic [LW-1:0] d;
    d = rand_line();
    txn(0, 1'b1, 32'h400, d, 1'b0, 1'b1, lat);
    checks++;
    if (lat != 10) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=10", lat); end
    drive(0, 1'b1, 1'b0, 32'h20, '0);
    gap = -1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (ack_a) begin gap = k; break; end
    end
    drive(0, 1'b0, 1'b0, 32'h20, '0);
    last_m[0] = mem_m[0][1];
    checks++;
    if (gap != 12) begin failures++; $display("FAIL b2b_ack_gap got=%0d exp=12", gap); end
    checks++;
    if (dout_a !== mem_m[0][1]) begin failures++; $display("FAIL b2b_refill got=%h exp=%h", dout_a, mem_m[0][1]); end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack_a) extra++;
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL b2b_extra_acks got=%0d exp=0", extra); end
    txn(0, 1'b0, 32'h400, '0, 1'b0, 1'b0, lat);
    checks++;
    if (dout_a !== d) begin failures++; $display("FAIL b2b_writeback got=%h exp=%h", dout_a, d); end
  endtask

  task automatic test_input_churn();
    int lat;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      logic [LW-1:0] d;
      a = $urandom();
      d = rand_line();
      txn(0, 1'b1, a, d, 1'b1, 1'b0, lat);
      checks++;
      if (lat != 10 || dout_a !== last_m[0]) begin
        failures++; $display("FAIL churn_wr lat=%0d data=%h exp lat=10 data=%h", lat, dout_a, last_m[0]);
      end
      txn(0, 1'b0, a, '0, 1'b1, 1'b0, lat);
      checks++;
      if (lat != 10 || dout_a !== d) begin
        failures++; $display("FAIL churn_rd lat=%0d data=%h exp lat=10 data=%h", lat, dout_a, d);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat, seen;
    logic [LW-1:0] d;
    d = rand_line();
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'hE0, d);
    @(posedge clk);
    for (int k = 0; k < 5; k++) @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    last_m[0] = '0;
    last_m[1] = '0;
    checks++;
    if (busy_a !== 1'b0 || dout_a !== '0) begin
      failures++; $display("FAIL abort_state busy=%b data=%h exp busy=0 data=0", busy_a, dout_a);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack_a) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abort_ack got=%0d exp=0", seen); end
    txn(0, 1'b0, 32'hE0, '0, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 10 || dout_a !== mem_m[0][7]) begin
      failures++; $display("FAIL abort_line7 lat=%0d data=%h exp lat=10 data=%h", lat, dout_a, mem_m[0][7]);
    end
  endtask

  task automatic test_random(input int s, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      logic w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      a = $urandom();
      txn(s, w, a, rand_line(), 1'b0, 1'b0, lat);
      checks++;
      if (lat != lat_m[s] || get_dout(s) !== last_m[s]) begin
        failures++;
        $display("FAIL random dut=%0d w=%b addr=%h lat=%0d data=%h exp lat=%0d data=%h",
                 s, w, a, lat, get_dout(s), lat_m[s], last_m[s]);
      end
    end
  endtask

  task automatic test_latency1_alias();
    int lat;
    txn(1, 1'b0, 32'h4060, '0, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL l1_latency got=%0d exp=1", lat); end
    checks++;
    if (dout_b !== {32{8'hA5}}) begin failures++; $display("FAIL l1_alias_data got=%h exp=%h", dout_b, {32{8'hA5}}); end
    @(negedge clk);
    checks++;
    if (ack_b !== 1'b0 || busy_b !== 1'b0) begin
      failures++; $display("FAIL l1_after_ack ack=%b busy=%b exp=0/0", ack_b, busy_b);
    end
  endtask

  initial begin
    test_reset();
    preload(0);
    preload(1);
    test_read_latency();
    test_write_read();
    test_back_to_back();
    test_input_churn();
    test_reset_abort();
    test_random(0, 20);
    test_latency1_alias();
    test_random(1, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
